// File: rtl/nco_multi.sv
// Multi-channel numerically controlled oscillator: per-channel phase accumulators
// with shadowed configuration that commits immediately or on the channel's next wrap.
module nco_multi #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int NUM_CH = 2,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     run,
  input  logic                     sync,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [DATA_W-1:0]        cfg_fcw,
  input  logic [DATA_W-1:0]        cfg_phase,
  input  logic [1:0]               cfg_mode,
  input  logic                     cfg_on_wrap,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        wrap,
  output logic                     out_valid
);

  typedef enum logic [1:0] {
    MODE_SAW    = 2'b00,
    MODE_SQUARE = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  // Config handshake: a write is taken on any rising edge where cfg_valid && cfg_ready;
  // cfg_ready is registered and stays low while any channel holds a deferred commit.
  logic [ACC_W-1:0]        acc_q      [NUM_CH];
  logic [ACC_W-1:0]        acc_d      [NUM_CH];
  logic [DATA_W-1:0]       fcw_q      [NUM_CH];
  logic [DATA_W-1:0]       fcw_d      [NUM_CH];
  logic [DATA_W-1:0]       phase_q    [NUM_CH];
  logic [DATA_W-1:0]       phase_d    [NUM_CH];
  mode_e                   mode_q     [NUM_CH];
  mode_e                   mode_d     [NUM_CH];
  logic [DATA_W-1:0]       sh_fcw_q   [NUM_CH];
  logic [DATA_W-1:0]       sh_fcw_d   [NUM_CH];
  logic [DATA_W-1:0]       sh_phase_q [NUM_CH];
  logic [DATA_W-1:0]       sh_phase_d [NUM_CH];
  mode_e                   sh_mode_q  [NUM_CH];
  mode_e                   sh_mode_d  [NUM_CH];
  logic [NUM_CH-1:0]       pending_q, pending_d;
  logic [NUM_CH-1:0]       wrapped_q, wrapped_d;
  logic [NUM_CH-1:0]       wrap_q, wrap_d;
  logic [NUM_CH*DATA_W-1:0] data_q, data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    cfg_ready_q, cfg_ready_d;
  logic                    accept;

  assign cfg_ready = cfg_ready_q;
  assign data_out  = data_q;
  assign wrap      = wrap_q;
  assign out_valid = out_valid_q;
  assign accept    = cfg_valid && cfg_ready_q;

  always_comb begin
    logic [ACC_W:0]      sum;
    logic                step_carry;
    logic                commit_pend;
    logic                wr;
    logic [DATA_W-1:0]   p;
    logic [DATA_W-1:0]   wave;
    pending_d   = pending_q;
    wrapped_d   = '0;
    data_d      = '0;
    wrap_d      = wrapped_q;
    out_valid_d = run;
    for (int i = 0; i < NUM_CH; i++) begin
      acc_d[i]      = acc_q[i];
      fcw_d[i]      = fcw_q[i];
      phase_d[i]    = phase_q[i];
      mode_d[i]     = mode_q[i];
      sh_fcw_d[i]   = sh_fcw_q[i];
      sh_phase_d[i] = sh_phase_q[i];
      sh_mode_d[i]  = sh_mode_q[i];

      // The step on a commit edge still uses the old fcw.
      sum        = {1'b0, acc_q[i]} + {1'b0, ACC_W'(fcw_q[i])};
      step_carry = run && sum[ACC_W];
      if (sync) begin
        acc_d[i] = '0;
      end else if (run) begin
        acc_d[i] = sum[ACC_W-1:0];
      end
      wrapped_d[i] = step_carry && !sync;

      // A stopped or zero-rate channel would never wrap, so commit at once.
      commit_pend = pending_q[i] && (step_carry || !run || (fcw_q[i] == '0));
      if (commit_pend) begin
        fcw_d[i]     = sh_fcw_q[i];
        phase_d[i]   = sh_phase_q[i];
        mode_d[i]    = sh_mode_q[i];
        pending_d[i] = 1'b0;
      end

      // Writes to a channel index beyond NUM_CH match nothing and are dropped.
      wr = accept && (int'(cfg_ch) == i);
      if (wr) begin
        sh_fcw_d[i]   = cfg_fcw;
        sh_phase_d[i] = cfg_phase;
        sh_mode_d[i]  = mode_e'(cfg_mode);
        if (cfg_on_wrap) begin
          pending_d[i] = 1'b1;
        end else begin
          fcw_d[i]   = cfg_fcw;
          phase_d[i] = cfg_phase;
          mode_d[i]  = mode_e'(cfg_mode);
        end
      end

      p = acc_q[i][ACC_W-1 -: DATA_W] + phase_q[i];
      case (mode_q[i])
        MODE_SAW:    wave = p;
        MODE_SQUARE: wave = {DATA_W{p[DATA_W-1]}};
        MODE_TRI:    wave = p[DATA_W-1] ? {~p[DATA_W-2:0], 1'b0} : {p[DATA_W-2:0], 1'b0};
        default:     wave = '0;
      endcase
      data_d[i*DATA_W +: DATA_W] = wave;
    end
    cfg_ready_d = ~(|pending_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]      <= '0;
        fcw_q[i]      <= '0;
        phase_q[i]    <= '0;
        mode_q[i]     <= MODE_OFF;
        sh_fcw_q[i]   <= '0;
        sh_phase_q[i] <= '0;
        sh_mode_q[i]  <= MODE_OFF;
      end
      pending_q   <= '0;
      wrapped_q   <= '0;
      wrap_q      <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]      <= acc_d[i];
        fcw_q[i]      <= fcw_d[i];
        phase_q[i]    <= phase_d[i];
        mode_q[i]     <= mode_d[i];
        sh_fcw_q[i]   <= sh_fcw_d[i];
        sh_phase_q[i] <= sh_phase_d[i];
        sh_mode_q[i]  <= sh_mode_d[i];
      end
      pending_q   <= pending_d;
      wrapped_q   <= wrapped_d;
      wrap_q      <= wrap_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

endmodule

// File: tb/tb_nco_multi.sv
// Scoreboard bench for nco_multi (DATA_W=8, ACC_W=16, NUM_CH=2): expected outputs are
// queued against absolute cycle numbers and compared by a negedge monitor.
module tb_nco_multi;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic        sync;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [0:0]  cfg_ch;
  logic [7:0]  cfg_fcw;
  logic [7:0]  cfg_phase;
  logic [1:0]  cfg_mode;
  logic        cfg_on_wrap;
  logic [15:0] data_out;
  logic [1:0]  wrap;
  logic        out_valid;

  nco_multi #(.DATA_W(8), .ACC_W(16), .NUM_CH(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .sync        (sync),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_fcw     (cfg_fcw),
    .cfg_phase   (cfg_phase),
    .cfg_mode    (cfg_mode),
    .cfg_on_wrap (cfg_on_wrap),
    .data_out    (data_out),
    .wrap        (wrap),
    .out_valid   (out_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [15:0] dm;
    logic [1:0]  wrap;
    logic [1:0]  wm;
    logic        valid;
    logic        ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input int c, input logic [15:0] d, input logic [15:0] dm,
                      input logic [1:0] w, input logic [1:0] wm,
                      input logic v, input logic r);
    exp_t e;
    e.cyc = c; e.data = d; e.dm = dm; e.wrap = w; e.wm = wm; e.valid = v; e.ready = r;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Fields compared as {data,wrap,out_valid,cfg_ready} after masking.
  always @(negedge clk) begin
    exp_t        e;
    logic [19:0] act;
    logic [19:0] req;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e   = exp_q.pop_front();
      act = {data_out & e.dm, wrap & e.wm, out_valid, cfg_ready};
      req = {e.data & e.dm, e.wrap & e.wm, e.valid, e.ready};
      checks++;
      if (e.cyc != cyc || act !== req) begin
        failures++;
        $display("FAIL out_cyc%0d actual=%h required=%h (data,wrap,valid,ready) at cyc %0d",
                 e.cyc, act, req, cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic cfg_write(input logic [0:0] ch, input logic [7:0] fcw, input logic [7:0] ph,
                           input logic [1:0] mode, input logic on_wrap);
    cfg_valid   = 1'b1;
    cfg_ch      = ch;
    cfg_fcw     = fcw;
    cfg_phase   = ph;
    cfg_mode    = mode;
    cfg_on_wrap = on_wrap;
    @(negedge clk);
    cfg_valid   = 1'b0;
    cfg_on_wrap = 1'b0;
  endtask

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int b;
    int c;
    int r;
    int s;
    int t;
    int u;
    int ks[12];
    reset_n = 1'b0; run = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_fcw = '0; cfg_phase = '0; cfg_mode = '0; cfg_on_wrap = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h0);

    b = cyc;
    push(b + 1, 16'h0000, 16'hFFFF, 2'b00, 2'b11, 1'b0, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);

    // ch0 saw, fcw 0x80: top byte steps every 2 cycles, wrap every 512
    cfg_write(1'b0, 8'h80, 8'h00, 2'b00, 1'b0);
    c  = cyc;
    ks = '{1, 2, 3, 4, 5, 6, 511, 512, 513, 514, 1025, 1026};
    foreach (ks[i]) begin
      push(c + ks[i], 16'(((ks[i] - 1) >> 1) & 8'hFF), 16'hFFFF,
           (ks[i] > 1 && ((ks[i] - 1) % 512) == 0) ? 2'b01 : 2'b00, 2'b11, 1'b1, 1'b1);
    end
    run = 1'b1;
    wait_until(c + 1026);
    run  = 1'b0;
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;

    // ch1 square, fcw 0: phase 0x80 -> 0xFF, phase 0x00 -> 0x00
    b = cyc;
    push(b + 2, 16'hFF00, 16'hFF00, 2'b00, 2'b11, 1'b0, 1'b1);
    push(b + 3, 16'hFF00, 16'hFF00, 2'b00, 2'b11, 1'b0, 1'b1);
    cfg_write(1'b1, 8'h00, 8'h80, 2'b01, 1'b0);
    wait_until(b + 4);
    b = cyc;
    push(b + 2, 16'h0000, 16'hFF00, 2'b00, 2'b11, 1'b0, 1'b1);
    push(b + 3, 16'h0000, 16'hFF00, 2'b00, 2'b11, 1'b0, 1'b1);
    cfg_write(1'b1, 8'h00, 8'h00, 2'b01, 1'b0);
    wait_until(b + 4);

    // ch0 triangle, fcw 0: phase 0x40 -> 0x80, phase 0xC0 -> 0x7E
    b = cyc;
    push(b + 2, 16'h0080, 16'h00FF, 2'b00, 2'b11, 1'b0, 1'b1);
    cfg_write(1'b0, 8'h00, 8'h40, 2'b10, 1'b0);
    wait_until(b + 4);
    b = cyc;
    push(b + 2, 16'h007E, 16'h00FF, 2'b00, 2'b11, 1'b0, 1'b1);
    cfg_write(1'b0, 8'h00, 8'hC0, 2'b10, 1'b0);
    wait_until(b + 4);

    // deferred write with run=0 commits on the next edge
    b = cyc;
    push(b + 1, 16'h0000, 16'h0000, 2'b00, 2'b11, 1'b0, 1'b0);
    push(b + 2, 16'h0000, 16'hFF00, 2'b00, 2'b11, 1'b0, 1'b1);
    push(b + 3, 16'h8000, 16'hFF00, 2'b00, 2'b11, 1'b0, 1'b1);
    cfg_write(1'b1, 8'h00, 8'h80, 2'b00, 1'b1);
    wait_until(b + 4);

    // ch0 fcw 0x80 running; deferred fcw 0x40 written at acc=0x1000
    cfg_write(1'b0, 8'h80, 8'h00, 2'b00, 1'b0);
    r = cyc;
    push(r + 33,  16'h0000, 16'h0000, 2'b00, 2'b11, 1'b1, 1'b0);
    push(r + 200, 16'h0000, 16'h0000, 2'b00, 2'b11, 1'b1, 1'b0);
    push(r + 511, 16'h00FF, 16'h00FF, 2'b00, 2'b11, 1'b1, 1'b0);
    push(r + 512, 16'h00FF, 16'h00FF, 2'b00, 2'b11, 1'b1, 1'b1);
    push(r + 513, 16'h0000, 16'h00FF, 2'b01, 2'b11, 1'b1, 1'b1);
    push(r + 516, 16'h0000, 16'h00FF, 2'b00, 2'b11, 1'b1, 1'b1);
    push(r + 517, 16'h0001, 16'h00FF, 2'b00, 2'b11, 1'b1, 1'b1);
    push(r + 521, 16'h0002, 16'h00FF, 2'b00, 2'b11, 1'b1, 1'b1);
    run = 1'b1;
    wait_until(r + 32);
    cfg_write(1'b0, 8'h40, 8'h00, 2'b00, 1'b1);

    // sync on the edge where ch0 would wrap, together with an immediate write
    s = r + 1535;
    wait_until(s);
    push(s + 2,  16'h0020, 16'h00FF, 2'b00, 2'b11, 1'b1, 1'b1);
    push(s + 3,  16'h0020, 16'h00FF, 2'b00, 2'b11, 1'b1, 1'b1);
    push(s + 18, 16'h0021, 16'h00FF, 2'b00, 2'b11, 1'b1, 1'b1);
    sync = 1'b1;
    cfg_write(1'b0, 8'h10, 8'h20, 2'b00, 1'b0);
    sync = 1'b0;
    wait_until(s + 19);

    // reset while a deferred write is pending
    t = cyc;
    push(t + 2, 16'h0000, 16'h0000, 2'b00, 2'b11, 1'b1, 1'b0);
    cfg_write(1'b0, 8'h01, 8'h00, 2'b00, 1'b1);
    wait_until(t + 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_data", 32'(data_out), 32'h0);
    chk("midrst_wrap", 32'(wrap), 32'h0);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_ready", 32'(cfg_ready), 32'h0);
    @(negedge clk);
    u = cyc;
    push(u + 1, 16'h0000, 16'hFFFF, 2'b00, 2'b11, 1'b1, 1'b1);
    push(u + 3, 16'h0055, 16'h00FF, 2'b00, 2'b11, 1'b1, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    cfg_write(1'b0, 8'h00, 8'h55, 2'b00, 1'b0);
    wait_until(u + 5);
    @(negedge clk);

    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL unchecked_cyc%0d actual=none required=compared", e.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
